// File: rtl/sdram_burst_controller.sv
// Single-FSM SDRAM controller: power-up init, auto-refresh and one fixed-length
// burst per host request, always closed with auto-precharge.
module sdram_burst_controller #(
    parameter int ROW_WIDTH        = 13,
    parameter int COL_WIDTH        = 9,
    parameter int BANK_WIDTH       = 2,
    parameter int DATA_WIDTH       = 16,
    parameter int CAS_LATENCY      = 3,
    parameter int BURST_LEN        = 4,
    parameter int T_RCD            = 2,
    parameter int T_RP             = 2,
    parameter int T_RFC            = 8,
    parameter int T_WR             = 2,
    parameter int INIT_CYCLES      = 100,
    parameter int REFRESH_INTERVAL = 519,
    localparam int HADDR_WIDTH     = BANK_WIDTH + ROW_WIDTH + COL_WIDTH,
    localparam int SDRADDR_WIDTH   = (ROW_WIDTH > 11) ? ROW_WIDTH : 11,
    localparam int MASK_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [HADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic [SDRADDR_WIDTH-1:0] addr,
    output logic [BANK_WIDTH-1:0]    bank_addr,
    output logic [DATA_WIDTH-1:0]    data_out,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     data_oe,
    output logic                     clock_enable,
    output logic                     cs_n,
    output logic                     ras_n,
    output logic                     cas_n,
    output logic                     we_n,
    output logic [MASK_WIDTH-1:0]    data_mask
);

    localparam int BL_LOG = $clog2(BURST_LEN);
    localparam int CNT_W  = $clog2(INIT_CYCLES + T_RFC + T_WR + T_RP + CAS_LATENCY
                                   + BURST_LEN + T_RCD + 2);
    localparam int REF_W  = $clog2(REFRESH_INTERVAL + 1) + 1;
    localparam logic [COL_WIDTH-1:0] COL_MASK = ~COL_WIDTH'((1 << BL_LOG) - 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    typedef enum logic [3:0] {
        INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS,
        IDLE, ACT, RCD_WAIT, RD_CMD, RD_DATA, WR_CMD, WR_DATA,
        RECOVER, REF, REF_WAIT
    } state_t;

    state_t                   state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [REF_W-1:0]         refresh_cnt_reg;
    logic [3:0]               cmd_reg;
    logic [SDRADDR_WIDTH-1:0] addr_reg;
    logic [BANK_WIDTH-1:0]    bank_reg;
    logic [COL_WIDTH-1:0]     col_reg;
    logic                     write_reg;
    logic                     wr_ready_reg;
    logic                     data_oe_reg;
    logic [MASK_WIDTH-1:0]    mask_reg;
    logic                     rd_valid_reg;
    logic [DATA_WIDTH-1:0]    rd_data_reg;

    logic [SDRADDR_WIDTH-1:0] act_addr;
    logic [SDRADDR_WIDTH-1:0] col_addr;
    logic [SDRADDR_WIDTH-1:0] mrs_addr;
    logic [SDRADDR_WIDTH-1:0] pre_all_addr;
    logic                     refresh_pending;
    logic                     in_init;
    logic                     col_go;

    always_comb begin
        act_addr                    = '0;
        act_addr[ROW_WIDTH-1:0]     = cmd_addr[COL_WIDTH +: ROW_WIDTH];
        col_addr                    = '0;
        col_addr[COL_WIDTH-1:0]     = col_reg;
        col_addr[10]                = 1'b1;
        mrs_addr                    = '0;
        mrs_addr[2:0]               = 3'(BL_LOG);
        mrs_addr[6:4]               = 3'(CAS_LATENCY);
        pre_all_addr                = '0;
        pre_all_addr[10]            = 1'b1;
    end

    assign refresh_pending = (refresh_cnt_reg >= REF_W'(REFRESH_INTERVAL));
    assign in_init = state_reg inside {INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS};
    // Column command follows ACT by exactly T_RCD cycles; T_RCD=1 skips RCD_WAIT.
    assign col_go  = ((state_reg == ACT) && (T_RCD <= 1)) ||
                     ((state_reg == RCD_WAIT) && (cnt_reg == CNT_W'(T_RCD - 2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= INIT_WAIT;
            cnt_reg         <= '0;
            refresh_cnt_reg <= '0;
            cmd_reg         <= CMD_NOP;
            addr_reg        <= '0;
            bank_reg        <= '0;
            col_reg         <= '0;
            write_reg       <= 1'b0;
            wr_ready_reg    <= 1'b0;
            data_oe_reg     <= 1'b0;
            mask_reg        <= '1;
            rd_valid_reg    <= 1'b0;
            rd_data_reg     <= '0;
        end else begin
            cmd_reg <= CMD_NOP;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (!in_init && (refresh_cnt_reg != '1))
                refresh_cnt_reg <= refresh_cnt_reg + REF_W'(1);

            case (state_reg)
                INIT_WAIT: if (cnt_reg == CNT_W'(INIT_CYCLES)) begin
                    state_reg <= INIT_PRE;
                    cmd_reg   <= CMD_PRE;
                    addr_reg  <= pre_all_addr;
                    cnt_reg   <= '0;
                end
                INIT_PRE: if (cnt_reg == CNT_W'(T_RP - 1)) begin
                    state_reg <= INIT_REF1;
                    cmd_reg   <= CMD_REF;
                    cnt_reg   <= '0;
                end
                INIT_REF1: if (cnt_reg == CNT_W'(T_RFC - 1)) begin
                    state_reg <= INIT_REF2;
                    cmd_reg   <= CMD_REF;
                    cnt_reg   <= '0;
                end
                INIT_REF2: if (cnt_reg == CNT_W'(T_RFC - 1)) begin
                    state_reg <= INIT_MRS;
                    cmd_reg   <= CMD_MRS;
                    addr_reg  <= mrs_addr;
                    cnt_reg   <= '0;
                end
                INIT_MRS: if (cnt_reg == CNT_W'(2)) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
                IDLE: begin
                    cnt_reg <= '0;
                    if (refresh_pending) begin
                        state_reg       <= REF;
                        cmd_reg         <= CMD_REF;
                        refresh_cnt_reg <= '0;
                    end else if (cmd_valid) begin
                        state_reg <= ACT;
                        cmd_reg   <= CMD_ACT;
                        addr_reg  <= act_addr;
                        bank_reg  <= cmd_addr[HADDR_WIDTH-1 -: BANK_WIDTH];
                        col_reg   <= cmd_addr[COL_WIDTH-1:0] & COL_MASK;
                        write_reg <= cmd_write;
                    end
                end
                ACT, RCD_WAIT: begin
                    if (col_go) begin
                        cmd_reg  <= write_reg ? CMD_WRITE : CMD_READ;
                        addr_reg <= col_addr;
                        mask_reg <= '0;
                        cnt_reg  <= '0;
                        if (write_reg) begin
                            state_reg    <= WR_CMD;
                            wr_ready_reg <= 1'b1;
                            data_oe_reg  <= 1'b1;
                        end else begin
                            state_reg <= RD_CMD;
                        end
                    end else if (state_reg == ACT) begin
                        state_reg <= RCD_WAIT;
                        cnt_reg   <= '0;
                    end
                end
                RD_CMD: begin
                    state_reg <= RD_DATA;
                    cnt_reg   <= '0;
                end
                RD_DATA: begin
                    // cnt_reg = k means this is the k+1-th cycle after READ.
                    if ((cnt_reg >= CNT_W'(CAS_LATENCY - 1)) &&
                        (cnt_reg <= CNT_W'(CAS_LATENCY + BURST_LEN - 2))) begin
                        rd_valid_reg <= 1'b1;
                        rd_data_reg  <= data_in;
                    end else begin
                        rd_valid_reg <= 1'b0;
                    end
                    if (cnt_reg == CNT_W'(CAS_LATENCY + BURST_LEN - 1)) begin
                        state_reg <= RECOVER;
                        mask_reg  <= '1;
                        cnt_reg   <= '0;
                    end
                end
                WR_CMD, WR_DATA: begin
                    if ((state_reg == WR_CMD && BURST_LEN == 1) ||
                        (state_reg == WR_DATA && cnt_reg == CNT_W'(BURST_LEN - 2))) begin
                        state_reg    <= RECOVER;
                        wr_ready_reg <= 1'b0;
                        data_oe_reg  <= 1'b0;
                        mask_reg     <= '1;
                        cnt_reg      <= '0;
                    end else if (state_reg == WR_CMD) begin
                        state_reg <= WR_DATA;
                        cnt_reg   <= '0;
                    end
                end
                RECOVER: if (cnt_reg == (write_reg ? CNT_W'(T_WR + T_RP - 1)
                                                   : CNT_W'(T_RP - 1))) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
                REF: begin
                    state_reg <= (T_RFC <= 1) ? IDLE : REF_WAIT;
                    cnt_reg   <= '0;
                end
                REF_WAIT: if (cnt_reg == CNT_W'(T_RFC - 2)) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
                default: begin
                    state_reg <= INIT_WAIT;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = cmd_reg;
    assign clock_enable = 1'b1;
    assign addr         = addr_reg;
    assign bank_addr    = bank_reg;
    assign data_out     = wr_data;
    assign data_oe      = data_oe_reg;
    assign wr_ready     = wr_ready_reg;
    assign data_mask    = mask_reg;
    assign rd_valid     = rd_valid_reg;
    assign rd_data      = rd_data_reg;
    assign busy         = (state_reg != IDLE);
    assign cmd_ready    = (state_reg == IDLE) && !refresh_pending;

endmodule
